// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: sequences the PLL reset, waits for lock with a
// timeout and retry budget, qualifies lock stability before releasing the
// system reset, and tracks loss-of-lock events while running.
module pll_lock_supervisor #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  input  logic       i_restart,
  output logic       o_pll_rst,
  output logic       o_sys_rst_n,
  output logic       o_ready,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt,
  output logic [2:0] o_state
);

  // Each timer is wide enough to hold its own terminal value.
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]  STB_TARGET = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [3:0]        RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [STB_W-1:0]  stable_cnt_reg, stable_cnt_next;
  logic [3:0]        retry_reg, retry_next;
  logic [7:0]        loss_reg, loss_next;
  logic              sync_meta_reg;
  logic              locked_s;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta_reg <= 1'b0;
      locked_s      <= 1'b0;
    end else begin
      sync_meta_reg <= i_pll_locked;
      locked_s      <= sync_meta_reg;
    end
  end

  // Next-state and counter update; restart overrides every other transition.
  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    stable_cnt_next = stable_cnt_reg;
    retry_next      = retry_reg;
    loss_next       = loss_reg;
    if (i_restart) begin
      state_next      = ST_HOLD;
      hold_cnt_next   = '0;
      wait_cnt_next   = '0;
      stable_cnt_next = '0;
      retry_next      = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next    = ST_WAIT;
            hold_cnt_next = '0;
            wait_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (locked_s) begin
            // This locked cycle is the first one of the stability count.
            wait_cnt_next   = '0;
            stable_cnt_next = STB_W'(1);
            if (STB_TARGET == STB_W'(1)) begin
              state_next = ST_RUN;
              retry_next = '0;
            end else begin
              state_next = ST_STABLE;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_next = '0;
            retry_next    = retry_reg + 4'd1;
            hold_cnt_next = '0;
            if ((retry_reg + 4'd1) == RETRY_MAX) begin
              state_next = ST_FAIL;
            end else begin
              state_next = ST_HOLD;
            end
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            // A dropout restarts qualification but is not a failed attempt.
            state_next      = ST_WAIT;
            wait_cnt_next   = '0;
            stable_cnt_next = '0;
          end else begin
            stable_cnt_next = stable_cnt_reg + 1'b1;
            if ((stable_cnt_reg + 1'b1) == STB_TARGET) begin
              state_next = ST_RUN;
              retry_next = '0;
            end
          end
        end
        ST_RUN: begin
          retry_next = '0;
          if (!locked_s) begin
            state_next      = ST_HOLD;
            hold_cnt_next   = '0;
            stable_cnt_next = '0;
            if (loss_reg != 8'hFF) begin
              loss_next = loss_reg + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          // Parked until an explicit restart; lock status is not considered.
        end
        default: begin
          state_next      = ST_HOLD;
          hold_cnt_next   = '0;
          wait_cnt_next   = '0;
          stable_cnt_next = '0;
        end
      endcase
    end
  end

  // State, counters and decoded outputs all update on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_HOLD;
      hold_cnt_reg   <= '0;
      wait_cnt_reg   <= '0;
      stable_cnt_reg <= '0;
      retry_reg      <= '0;
      loss_reg       <= '0;
      o_pll_rst      <= 1'b1;
      o_sys_rst_n    <= 1'b0;
      o_ready        <= 1'b0;
      o_fail         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      stable_cnt_reg <= stable_cnt_next;
      retry_reg      <= retry_next;
      loss_reg       <= loss_next;
      o_pll_rst      <= (state_next == ST_HOLD) || (state_next == ST_FAIL);
      o_sys_rst_n    <= (state_next == ST_RUN);
      o_ready        <= (state_next == ST_RUN);
      o_fail         <= (state_next == ST_FAIL);
    end
  end

  assign o_retry_cnt = retry_reg;
  assign o_loss_cnt  = loss_reg;
  assign o_state     = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short parameters
// (hold 4, timeout 20, stable 8, two retries).
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int exp_loss;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pll_locked(pll_locked),
    .i_restart   (restart),
    .o_pll_rst   (pll_rst),
    .o_sys_rst_n (sys_rst_n),
    .o_ready     (ready),
    .o_fail      (fail),
    .o_retry_cnt (retry_cnt),
    .o_loss_cnt  (loss_cnt),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 rst_n   = 1'b0;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst_n", 32'(sys_rst_n), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_loss", 32'(loss_cnt), 0);
    step(2);
    rst_n = 1'b1;

    // Clean bring-up: four HOLD cycles, lock 5 cycles into WAIT_LOCK.
    step(3);
    check("hold3_state", 32'(state), 0);
    check("hold3_pll_rst", 32'(pll_rst), 1);
    step(1);
    check("wait_state", 32'(state), 1);
    check("wait_pll_rst", 32'(pll_rst), 0);
    check("wait_sys_rst_n", 32'(sys_rst_n), 0);
    step(5);
    pll_locked = 1'b1;
    step(2);
    check("sync_delay_state", 32'(state), 1);
    step(1);
    check("stable_entry", 32'(state), 2);
    step(6);
    check("stable_late_state", 32'(state), 2);
    check("stable_late_ready", 32'(ready), 0);
    step(1);
    check("run_state", 32'(state), 3);
    check("run_ready", 32'(ready), 1);
    check("run_sys_rst_n", 32'(sys_rst_n), 1);
    check("run_pll_rst", 32'(pll_rst), 0);
    check("run_retry", 32'(retry_cnt), 0);

    // Loss in RUN: visible three edges after the input drops.
    pll_locked = 1'b0;
    step(2);
    check("loss_pre_ready", 32'(ready), 1);
    step(1);
    check("loss_state", 32'(state), 0);
    check("loss_ready", 32'(ready), 0);
    check("loss_sys_rst_n", 32'(sys_rst_n), 0);
    check("loss_cnt1", 32'(loss_cnt), 1);
    check("loss_pll_rst", 32'(pll_rst), 1);

    // Unstable lock: one-cycle dropout after five stable cycles.
    pll_locked = 1'b1;
    step(4);
    check("unst_wait", 32'(state), 1);
    step(1);
    check("unst_stable", 32'(state), 2);
    step(2);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    check("unst_stable5", 32'(state), 2);
    step(1);
    check("unst_back_wait", 32'(state), 1);
    check("unst_retry", 32'(retry_cnt), 0);
    step(1);
    check("unst_restable", 32'(state), 2);
    step(6);
    check("unst_not_yet", 32'(state), 2);
    step(1);
    check("unst_run", 32'(state), 3);
    check("unst_ready", 32'(ready), 1);

    // One timeout, then restart coinciding with the second timeout.
    pll_locked = 1'b0;
    step(3);
    check("loss2_state", 32'(state), 0);
    check("loss2_cnt", 32'(loss_cnt), 2);
    step(4);
    check("to1_wait", 32'(state), 1);
    step(19);
    check("to1_last_state", 32'(state), 1);
    check("to1_last_retry", 32'(retry_cnt), 0);
    step(1);
    check("to1_state", 32'(state), 0);
    check("to1_retry", 32'(retry_cnt), 1);
    check("to1_pll_rst", 32'(pll_rst), 1);
    step(4);
    check("to2_wait", 32'(state), 1);
    step(19);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("simul_state", 32'(state), 0);
    check("simul_retry", 32'(retry_cnt), 0);
    check("simul_fail", 32'(fail), 0);

    // Timeout to FAIL: two full attempts with no lock.
    step(4);
    step(20);
    check("fa1_state", 32'(state), 0);
    check("fa1_retry", 32'(retry_cnt), 1);
    step(4);
    step(19);
    check("fa2_last_state", 32'(state), 1);
    check("fa2_last_retry", 32'(retry_cnt), 1);
    step(1);
    check("fail_state", 32'(state), 4);
    check("fail_flag", 32'(fail), 1);
    check("fail_retry", 32'(retry_cnt), 2);
    check("fail_pll_rst", 32'(pll_rst), 1);
    check("fail_sys_rst_n", 32'(sys_rst_n), 0);
    check("fail_ready", 32'(ready), 0);
    pll_locked = 1'b1;
    step(100);
    check("fail_hold_state", 32'(state), 4);
    check("fail_hold_flag", 32'(fail), 1);
    check("fail_hold_pll_rst", 32'(pll_rst), 1);
    check("fail_hold_retry", 32'(retry_cnt), 2);

    // Restart out of FAIL keeps the loss count.
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("rs_state", 32'(state), 0);
    check("rs_retry", 32'(retry_cnt), 0);
    check("rs_loss", 32'(loss_cnt), 2);
    check("rs_fail", 32'(fail), 0);
    check("rs_pll_rst", 32'(pll_rst), 1);
    step(11);
    check("rs_stable", 32'(state), 2);
    step(1);
    check("rs_run", 32'(state), 3);

    // Repeated losses saturate the loss counter at 255.
    exp_loss = 2;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      step(3);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      check("sat_loss", 32'(loss_cnt), 32'(exp_loss));
      check("sat_state", 32'(state), 0);
      pll_locked = 1'b1;
      step(12);
      check("sat_ready", 32'(ready), 1);
    end
    check("sat_final", 32'(loss_cnt), 255);

    // Asynchronous reset mid-RUN, between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_sys_rst_n", 32'(sys_rst_n), 0);
    check("arst_pll_rst", 32'(pll_rst), 1);
    check("arst_ready", 32'(ready), 0);
    check("arst_loss", 32'(loss_cnt), 0);
    check("arst_retry", 32'(retry_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
